// File: rtl/alu_pkg.sv
// Shared definitions for the ALU board loader: FSM state encoding,
// ALU opcodes and load-mode constants.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_WAIT_OP = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational ALU core.
// Ports:
//   i_dato_a, i_dato_b : operands (NB_DATA)
//   i_operador         : opcode (NB_OPERADOR)
//   o_resultado        : result, truncated to NB_DATA; unknown opcodes give 0
module alu
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA     = 6,
  parameter int unsigned NB_OPERADOR = 6
) (
  input  logic [NB_DATA-1:0]     i_dato_a,
  input  logic [NB_DATA-1:0]     i_dato_b,
  input  logic [NB_OPERADOR-1:0] i_operador,
  output logic [NB_DATA-1:0]     o_resultado
);

  always_comb begin
    o_resultado = '0;
    case (i_operador)
      NB_OPERADOR'(OP_ADD): o_resultado = i_dato_a + i_dato_b;
      NB_OPERADOR'(OP_SUB): o_resultado = i_dato_a - i_dato_b;
      NB_OPERADOR'(OP_AND): o_resultado = i_dato_a & i_dato_b;
      NB_OPERADOR'(OP_OR):  o_resultado = i_dato_a | i_dato_b;
      default:              o_resultado = '0;
    endcase
  end

endmodule

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter and rising-edge
// pulse generator.
// Ports:
//   clk      : system clock
//   i_rst_n  : synchronous reset, active-low
//   i_btn    : raw asynchronous button level
//   o_pulse  : one-cycle pulse, 2 + DEBOUNCE_CYCLES cycles after a clean rise
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NB_DEBOUNCE     = 20
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

  logic                   sync1;
  logic                   sync2;
  logic                   level;
  logic [1:0]             prime;
  logic [NB_DEBOUNCE-1:0] cnt;

  // The accepted level comes out of reset as "pressed", so a button held
  // through reset has to be seen released before a new press can pulse.
  // Counting waits two cycles for the cleared synchroniser to refill, so
  // its reset zeros are never mistaken for a release.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prime   <= '0;
      cnt     <= '0;
      level   <= 1'b1;
      o_pulse <= 1'b0;
    end else begin
      sync1   <= i_btn;
      sync2   <= sync1;
      prime   <= {prime[0], 1'b1};
      o_pulse <= 1'b0;
      if (!prime[1] || (sync2 == level)) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        level   <= sync2;
        o_pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_loader.sv
// Board-level ALU loader: debounced buttons load operand A, operand B and
// the opcode from the switches, either directly or through a guided
// A -> B -> op sequence, and show the registered ALU result on the LEDs.
// Ports:
//   clk, i_rst_n            : clock, synchronous active-low reset
//   i_sw                    : switch data (opcode in the low NB_OPERADOR bits)
//   i_btn_l/i_btn_c/i_btn_r : raw buttons loading A / B / opcode
//   i_mode                  : 0 direct load, 1 sequenced load
//   o_led                   : registered ALU result
//   o_valid, o_zero         : result complete / complete and zero
//   o_state                 : FSM state
module alu_seq_loader
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA         = 6,
  parameter int unsigned NB_OPERADOR     = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NB_DEBOUNCE     = 20
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_l,
  input  logic               i_btn_c,
  input  logic               i_btn_r,
  input  logic               i_mode,
  output logic [NB_DATA-1:0] o_led,
  output logic               o_valid,
  output logic               o_zero,
  output logic [1:0]         o_state
);

  logic pulse_l, pulse_c, pulse_r;
  logic take_l, take_c, take_r;
  logic mode_q, mode_chg;
  logic seen_a, seen_b, seen_op;
  logic refresh;
  logic valid_d;

  logic [NB_DATA-1:0]     dato_a, dato_b, alu_result, led_d;
  logic [NB_OPERADOR-1:0] operador;
  state_t                 state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DEBOUNCE(NB_DEBOUNCE)) u_db_l (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_l), .o_pulse(pulse_l)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DEBOUNCE(NB_DEBOUNCE)) u_db_c (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_c), .o_pulse(pulse_c)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DEBOUNCE(NB_DEBOUNCE)) u_db_r (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn_r), .o_pulse(pulse_r)
  );

  alu #(.NB_DATA(NB_DATA), .NB_OPERADOR(NB_OPERADOR)) u_alu (
    .i_dato_a(dato_a), .i_dato_b(dato_b), .i_operador(operador), .o_resultado(alu_result)
  );

  // refresh marks the cycle after a load that must reach the LEDs, so
  // o_led/o_valid/o_zero all land two cycles after the button pulse.
  always_comb begin
    take_l   = pulse_l;
    take_c   = pulse_c & ~pulse_l;
    take_r   = pulse_r & ~pulse_l & ~pulse_c;
    mode_chg = (i_mode != mode_q);
    led_d    = refresh ? alu_result : o_led;
    valid_d  = 1'b0;
    if (mode_chg) begin
      led_d = o_led;
    end else if (mode_q == MODE_DIRECT) begin
      valid_d = seen_a & seen_b & seen_op;
    end else begin
      valid_d = (state == ST_SHOW) && !take_l;
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= i_mode;
    if (!i_rst_n) begin
      state    <= ST_WAIT_A;
      dato_a   <= '0;
      dato_b   <= '0;
      operador <= '0;
      seen_a   <= 1'b0;
      seen_b   <= 1'b0;
      seen_op  <= 1'b0;
      refresh  <= 1'b0;
      o_led    <= '0;
      o_valid  <= 1'b0;
      o_zero   <= 1'b0;
    end else begin
      refresh <= 1'b0;
      o_led   <= led_d;
      o_valid <= valid_d;
      o_zero  <= valid_d && (led_d == '0);
      if (mode_chg) begin
        state   <= ST_WAIT_A;
        seen_a  <= 1'b0;
        seen_b  <= 1'b0;
        seen_op <= 1'b0;
      end else if (mode_q == MODE_DIRECT) begin
        state <= ST_WAIT_A;
        if (take_l) begin
          dato_a  <= i_sw;
          seen_a  <= 1'b1;
          refresh <= 1'b1;
        end
        if (take_c) begin
          dato_b  <= i_sw;
          seen_b  <= 1'b1;
          refresh <= 1'b1;
        end
        if (take_r) begin
          operador <= i_sw[NB_OPERADOR-1:0];
          seen_op  <= 1'b1;
          refresh  <= 1'b1;
        end
      end else begin
        case (state)
          ST_WAIT_A: if (take_l) begin
            dato_a <= i_sw;
            state  <= ST_WAIT_B;
          end
          ST_WAIT_B: if (take_c) begin
            dato_b <= i_sw;
            state  <= ST_WAIT_OP;
          end
          ST_WAIT_OP: if (take_r) begin
            operador <= i_sw[NB_OPERADOR-1:0];
            state    <= ST_SHOW;
            refresh  <= 1'b1;
          end
          ST_SHOW: if (take_l) begin
            dato_a <= i_sw;
            state  <= ST_WAIT_B;
          end
          default: state <= ST_WAIT_A;
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_seq_loader.sv
// Self-checking bench for alu_seq_loader with a short debounce window.
module tb_alu_seq_loader;
  import alu_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sw;
  logic       bl, bc, br, mode;
  logic [5:0] led;
  logic       valid, zero;
  logic [1:0] st;

  always #5 clk = ~clk;

  alu_seq_loader #(
    .NB_DATA(6), .NB_OPERADOR(6), .DEBOUNCE_CYCLES(D), .NB_DEBOUNCE(4)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_btn_l(bl), .i_btn_c(bc),
    .i_btn_r(br), .i_mode(mode), .o_led(led), .o_valid(valid),
    .o_zero(zero), .o_state(st)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise the masked buttons (bit0 L, bit1 C, bit2 R) long enough for one
  // accepted press, then release and let the release settle.
  task automatic press(input logic [2:0] mask, input logic [5:0] v);
    sw = v;
    if (mask[0]) bl = 1'b1;
    if (mask[1]) bc = 1'b1;
    if (mask[2]) br = 1'b1;
    tick(D + 4);
    if (mask[0]) bl = 1'b0;
    if (mask[1]) bc = 1'b0;
    if (mask[2]) br = 1'b0;
    tick(D + 4);
  endtask

  // ---------------- transaction-level reference model ----------------
  int         m_a, m_b, m_led, m_step;
  logic [5:0] m_op;
  bit         m_valid, m_mode, m_sa, m_sb, m_so;

  function automatic int alu_ref(input int a, input int b, input logic [5:0] op);
    int r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b + 64;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = 0;
    endcase
    return r % 64;
  endfunction

  task automatic model_clear(input bit full);
    if (full) begin
      m_a = 0; m_b = 0; m_op = '0; m_led = 0;
    end
    m_step = 0; m_valid = 0; m_sa = 0; m_sb = 0; m_so = 0;
  endtask

  task automatic model_press(input logic [2:0] mask, input logic [5:0] v);
    int btn;
    btn = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : -1;
    if (!m_mode) begin
      if (btn == 0) begin m_a = v; m_sa = 1; end
      if (btn == 1) begin m_b = v; m_sb = 1; end
      if (btn == 2) begin m_op = v; m_so = 1; end
      if (btn >= 0) begin
        m_led   = alu_ref(m_a, m_b, m_op);
        m_valid = m_sa && m_sb && m_so;
      end
    end else begin
      if (m_step == 0 && btn == 0) begin m_a = v; m_step = 1; end
      else if (m_step == 1 && btn == 1) begin m_b = v; m_step = 2; end
      else if (m_step == 2 && btn == 2) begin
        m_op = v; m_step = 3; m_led = alu_ref(m_a, m_b, m_op); m_valid = 1;
      end else if (m_step == 3 && btn == 0) begin
        m_a = v; m_step = 1; m_valid = 0;
      end
    end
  endtask

  task automatic check_model(input int n);
    string s;
    s = $sformatf("rand%0d", n);
    check({s, ".led"}, led, m_led);
    check({s, ".valid"}, valid, m_valid);
    check({s, ".zero"}, zero, (m_valid && m_led == 0) ? 1 : 0);
    check({s, ".state"}, st, m_mode ? m_step : 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       mode;
    logic [2:0] mask;
    logic [5:0] sw;
    logic [5:0] led;
    logic       valid;
    logic       zero;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 3'b001, 6'd5,   6'd0, 1'b0, 1'b0, 2'd1};
    tbl[1]  = '{1'b1, 3'b010, 6'd3,   6'd0, 1'b0, 1'b0, 2'd2};
    tbl[2]  = '{1'b1, 3'b100, OP_ADD, 6'd8, 1'b1, 1'b0, 2'd3};
    tbl[3]  = '{1'b1, 3'b001, 6'd7,   6'd8, 1'b0, 1'b0, 2'd1};
    tbl[4]  = '{1'b1, 3'b010, 6'd7,   6'd8, 1'b0, 1'b0, 2'd2};
    tbl[5]  = '{1'b1, 3'b100, OP_SUB, 6'd0, 1'b1, 1'b1, 2'd3};
    tbl[6]  = '{1'b1, 3'b010, 6'd9,   6'd0, 1'b1, 1'b1, 2'd3};
    tbl[7]  = '{1'b1, 3'b100, OP_OR,  6'd0, 1'b1, 1'b1, 2'd3};
    tbl[8]  = '{1'b0, 3'b100, OP_AND, 6'd7, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 3'b001, 6'd12,  6'd4, 1'b0, 1'b0, 2'd0};
    tbl[10] = '{1'b0, 3'b010, 6'd10,  6'd8, 1'b1, 1'b0, 2'd0};

    rst_n = 1'b0; mode = 1'b1; sw = '0; bl = 0; bc = 0; br = 0;
    tick(3);
    rst_n = 1'b1;
    check("reset.led", led, 0);
    check("reset.valid", valid, 0);
    check("reset.zero", zero, 0);
    check("reset.state", st, 0);
    tick(10);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].mode != mode) begin
        mode = tbl[i].mode;
        tick(3);
        check($sformatf("vec%0d.modechg_state", i), st, 0);
        check($sformatf("vec%0d.modechg_valid", i), valid, 0);
      end
      press(tbl[i].mask, tbl[i].sw);
      check($sformatf("vec%0d.led", i), led, tbl[i].led);
      check($sformatf("vec%0d.valid", i), valid, tbl[i].valid);
      check($sformatf("vec%0d.zero", i), zero, tbl[i].zero);
      check($sformatf("vec%0d.state", i), st, tbl[i].st);
    end

    // Direct -> sequenced: operands and LEDs kept, flags and FSM cleared.
    mode = 1'b1;
    tick(3);
    check("to_seq.state", st, 0);
    check("to_seq.valid", valid, 0);
    check("to_seq.led", led, 8);

    // R pulse to LED latency in sequenced mode.
    press(3'b001, 6'd1);
    press(3'b010, 6'd2);
    check("lat.pre_state", st, 2);
    sw = OP_ADD;
    br = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 6) check("lat.k6_state", st, 2);
      if (k == 7) begin
        check("lat.k7_state", st, 3);
        check("lat.k7_led", led, 8);
        check("lat.k7_valid", valid, 0);
      end
      if (k == 8) begin
        check("lat.k8_led", led, 3);
        check("lat.k8_valid", valid, 1);
      end
    end
    br = 1'b0;
    tick(D + 4);

    // Direct mode bounce handling.
    mode = 1'b0;
    tick(3);
    check("direct.entry_led", led, 3);
    press(3'b100, OP_OR);
    check("direct.op_led", led, 3);
    check("direct.op_valid", valid, 0);
    press(3'b001, 6'd4);
    press(3'b010, 6'd2);
    check("direct.led", led, 6);
    check("direct.valid", valid, 1);

    sw = 6'h3F;
    bl = 1'b1;
    tick(3);
    bl = 1'b0;
    tick(12);
    check("glitch.led", led, 6);

    sw = 6'd8;
    bl = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 6) bl = 1'b0;
      if (k == 7) check("hold6.k7_led", led, 6);
      if (k == 8) check("hold6.k8_led", led, 10);
    end
    tick(12);
    check("hold6.after_led", led, 10);

    press(3'b011, 6'd16);
    check("simul.led", led, 18);
    check("simul.valid", valid, 1);

    // Reset while R is held in WAIT_OP.
    mode = 1'b1;
    tick(3);
    press(3'b001, 6'd1);
    press(3'b010, 6'd2);
    check("rstR.pre_state", st, 2);
    sw = OP_ADD;
    br = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("rstR.state", st, 0);
    check("rstR.led", led, 0);
    check("rstR.valid", valid, 0);
    tick(20);
    press(3'b001, 6'd5);
    press(3'b010, 6'd6);
    check("rstR.held_state", st, 2);
    br = 1'b0;
    tick(D + 4);
    check("rstR.release_state", st, 2);
    press(3'b100, OP_ADD);
    check("rstR.repress_state", st, 3);
    check("rstR.repress_led", led, 11);

    // Reset while L is held: a held L must not advance WAIT_A afterwards.
    sw = 6'd9;
    bl = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("rstL.held_state", st, 0);
    bl = 1'b0;
    tick(D + 4);
    check("rstL.release_state", st, 0);
    press(3'b001, 6'd9);
    check("rstL.repress_state", st, 1);

    // Randomised transactions against the reference model.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    model_clear(1);
    m_mode = mode;
    for (int n = 0; n < 40; n++) begin
      logic [2:0] mask;
      logic [5:0] v;
      if ($urandom_range(0, 7) == 0) begin
        mode = ~mode;
        m_mode = mode;
        model_clear(0);
        tick(3);
      end
      mask = 3'(1 << $urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) mask = mask | 3'(1 << $urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0: v = OP_ADD;
        1: v = OP_SUB;
        2: v = OP_AND;
        3: v = OP_OR;
        default: v = 6'($urandom);
      endcase
      press(mask, v);
      model_press(mask, v);
      check_model(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
